// File: rtl/au_pkg.sv
// Shared types and constants for the shared add/multiply scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package au_pkg;

  localparam logic OP_ADD   = 1'b0;
  localparam logic OP_MUL   = 1'b1;
  localparam int   LAT_DFLT = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } state_t;

  // One in-flight slot: occupied flag plus the requester that issued it.
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/au_share_ctrl_if.sv
// Client-side request/response bundle for the shared arithmetic scheduler.
// Latency: n/a (wires only).
// Backpressure: per-requester valid/ready on requests; responses are strobes with no backpressure.
interface au_share_ctrl_if #(
  parameter int DW = 8,
  parameter int RW = 2 * DW
);
  logic          req0_valid;
  logic          req0_ready;
  logic [DW-1:0] req0_a;
  logic [DW-1:0] req0_b;
  logic          req0_op;
  logic          req1_valid;
  logic          req1_ready;
  logic [DW-1:0] req1_a;
  logic [DW-1:0] req1_b;
  logic          req1_op;
  logic          rsp0_valid;
  logic          rsp1_valid;
  logic [RW-1:0] rsp_data;

  // Client side: issues requests, consumes responses.
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data
  );

  // Scheduler side.
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
// Latency: grant is combinational; pointer updates on the clock edge of a granted cycle.
// Backpressure: en=0 freezes the pointer (grant still computed, caller masks it).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // Id of the most recently granted requester; reset to 1 so req0 wins the first tie.
  logic last_id;

  // Grant: lone requester wins, tie goes to the one not granted last.
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last_id)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end

  // Pointer moves only when a grant is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id <= 1'b1;
    end else if (en && (gnt != 2'b00)) begin
      last_id <= gnt[1];
    end
  end

endmodule

// File: rtl/au_share_ctrl.sv
// Shares one pipelined add/multiply unit between two requesters, with drain/quiesce control.
// Latency: issue is same-cycle as accept; response strobe LAT cycles after accept.
// Backpressure: one accept per cycle, round-robin; ready held low while draining; no response backpressure.
module au_share_ctrl
  import au_pkg::*;
#(
  parameter int DW  = 8,
  parameter int RW  = 2 * DW,
  parameter int LAT = LAT_DFLT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  au_share_ctrl_if.slave       cif,
  output logic [DW-1:0]        au_a,
  output logic [DW-1:0]        au_b,
  output logic                 au_op_sel,
  input  logic [RW-1:0]        au_result,
  input  logic                 drain_req,
  output logic                 drain_done,
  output logic                 busy
);

  state_t     state;
  state_t     state_nxt;
  tag_t       tag [LAT];
  logic [1:0] gnt;
  logic       run;
  logic       accept;
  logic       win_id;
  logic       ahead_busy;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({cif.req1_valid, cif.req0_valid}),
    .en    (run),
    .gnt   (gnt)
  );

  assign accept = run & (gnt != 2'b00);
  assign win_id = gnt[1];

  // Issue mux: winner's operands on accept, an all-zero bubble otherwise.
  always_comb begin
    au_a      = '0;
    au_b      = '0;
    au_op_sel = OP_ADD;
    if (accept) begin
      au_a      = win_id ? cif.req1_a  : cif.req0_a;
      au_b      = win_id ? cif.req1_b  : cif.req0_b;
      au_op_sel = win_id ? cif.req1_op : cif.req0_op;
    end
  end

  // Tag pipe tracks the unit's stages one-for-one; reset discards in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) tag[i] <= '0;
    end else begin
      tag[0] <= '{valid: accept, id: win_id};
      for (int i = 1; i < LAT; i++) tag[i] <= tag[i-1];
    end
  end

  // Occupancy: busy covers every stage; ahead_busy excludes the stage retiring now,
  // so the drain can complete in the same cycle the last response leaves.
  always_comb begin
    busy       = 1'b0;
    ahead_busy = 1'b0;
    for (int i = 0; i < LAT; i++)     busy       = busy | tag[i].valid;
    for (int i = 0; i < LAT - 1; i++) ahead_busy = ahead_busy | tag[i].valid;
  end

  // Response strobe steered by the tag leaving the last stage.
  always_comb begin
    cif.rsp0_valid = tag[LAT-1].valid & ~tag[LAT-1].id;
    cif.rsp1_valid = tag[LAT-1].valid &  tag[LAT-1].id;
    cif.rsp_data   = tag[LAT-1].valid ? au_result : '0;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // FSM next state: dropping drain_req always returns to normal operation.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (drain_req) state_nxt = DRAIN;
      DRAIN:   if (!drain_req)      state_nxt = RUN;
               else if (!ahead_busy) state_nxt = DRAINED;
      DRAINED: if (!drain_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // FSM outputs: acceptance only in RUN, done flag only in DRAINED.
  always_comb begin
    run            = (state == RUN);
    drain_done     = (state == DRAINED);
    cif.req0_ready = run & gnt[0];
    cif.req1_ready = run & gnt[1];
  end

endmodule

// File: tb/tb_au_share_ctrl.sv
// Randomised and directed bench for au_share_ctrl against a transaction-level reference model.
// Latency: model predicts responses at accept cycle + LAT.
// Backpressure: requesters hold operands until the model predicts acceptance.
module tb_au_share_ctrl;
  import au_pkg::*;

  localparam int DW  = 8;
  localparam int RW  = 16;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] au_a;
  logic [DW-1:0] au_b;
  logic          au_op_sel;
  logic [RW-1:0] au_result;
  logic          drain_req = 1'b0;
  logic          drain_done;
  logic          busy;

  always #5 clk = ~clk;

  au_share_ctrl_if #(.DW(DW), .RW(RW)) cif ();

  au_share_ctrl #(.DW(DW), .RW(RW), .LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cif        (cif),
    .au_a       (au_a),
    .au_b       (au_b),
    .au_op_sel  (au_op_sel),
    .au_result  (au_result),
    .drain_req  (drain_req),
    .drain_done (drain_done),
    .busy       (busy)
  );

  // Stand-in for the arithmetic unit: fixed-latency pipe, reset by ~rst_n like the real one.
  logic [RW-1:0] au_pipe [LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) au_pipe[i] <= '0;
    end else begin
      au_pipe[0] <= (au_op_sel == OP_MUL) ? RW'(au_a) * RW'(au_b) : RW'(au_a) + RW'(au_b);
      for (int i = 1; i < LAT; i++) au_pipe[i] <= au_pipe[i-1];
    end
  end
  assign au_result = au_pipe[LAT-1];

  // Reference model: list of expected responses plus grant history and drain mode.
  typedef struct {
    int            due;
    bit            id;
    logic [RW-1:0] data;
  } exp_t;

  exp_t          inflight[$];
  int            cyc = 0;
  int            last_gnt = 1;
  int            mode = 0;          // 0 run, 1 draining, 2 drained
  bit            pv [2];
  logic [DW-1:0] pa [2];
  logic [DW-1:0] pb [2];
  bit            pop [2];
  int            acc_cnt [2];
  int            n_cmp = 0;
  int            n_bad = 0;
  bit            saw_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive();
    cif.req0_valid = pv[0]; cif.req0_a = pa[0]; cif.req0_b = pb[0]; cif.req0_op = pop[0];
    cif.req1_valid = pv[1]; cif.req1_a = pa[1]; cif.req1_b = pb[1]; cif.req1_op = pop[1];
  endtask

  task automatic set_req(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b, input bit op);
    pv[r] = 1'b1; pa[r] = a; pb[r] = b; pop[r] = op;
  endtask

  task automatic refill(input int r, input int pct);
    if (!pv[r] && ($urandom_range(99) < pct))
      set_req(r, DW'($urandom), DW'($urandom), 1'($urandom_range(1)));
  endtask

  // One clock cycle: drive, check all outputs mid-cycle, then advance the model.
  task automatic step();
    int            w;
    bit            rsp_e [2];
    logic [RW-1:0] d_e;
    exp_t          e;
    drive();
    @(negedge clk);
    w = -1;
    if (mode == 0) begin
      if (pv[0] && pv[1]) w = (last_gnt == 0) ? 1 : 0;
      else if (pv[0])     w = 0;
      else if (pv[1])     w = 1;
    end
    chk("req0_ready", 32'(cif.req0_ready), 32'(w == 0));
    chk("req1_ready", 32'(cif.req1_ready), 32'(w == 1));
    chk("au_a",      32'(au_a),      (w >= 0) ? 32'(pa[w])  : 32'd0);
    chk("au_b",      32'(au_b),      (w >= 0) ? 32'(pb[w])  : 32'd0);
    chk("au_op_sel", 32'(au_op_sel), (w >= 0) ? 32'(pop[w]) : 32'd0);
    rsp_e[0] = 1'b0; rsp_e[1] = 1'b0; d_e = '0;
    if (inflight.size() > 0 && inflight[0].due == cyc) begin
      rsp_e[inflight[0].id] = 1'b1;
      d_e = inflight[0].data;
    end
    chk("rsp0_valid", 32'(cif.rsp0_valid), 32'(rsp_e[0]));
    chk("rsp1_valid", 32'(cif.rsp1_valid), 32'(rsp_e[1]));
    chk("rsp_data",   32'(cif.rsp_data),   32'(d_e));
    chk("busy",       32'(busy),           32'(inflight.size() > 0));
    chk("drain_done", 32'(drain_done),     32'(mode == 2));
    if (drain_done) saw_done = 1'b1;
    if (rsp_e[0] || rsp_e[1]) void'(inflight.pop_front());
    if (w >= 0) begin
      e.due  = cyc + LAT;
      e.id   = w[0];
      e.data = pop[w] ? RW'(pa[w]) * RW'(pb[w]) : RW'(pa[w]) + RW'(pb[w]);
      inflight.push_back(e);
      last_gnt = w;
      pv[w] = 1'b0;
      acc_cnt[w]++;
    end
    case (mode)
      0: if (drain_req) mode = 1;
      1: if (!drain_req) mode = 0; else if (inflight.size() == 0) mode = 2;
      default: if (!drain_req) mode = 0;
    endcase
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reset asserted between edges; outputs checked while held, model wiped.
  task automatic do_reset();
    rst_n = 1'b0;
    drain_req = 1'b0;
    pv[0] = 1'b0; pv[1] = 1'b0;
    drive();
    #3;
    chk("rst_ready0", 32'(cif.req0_ready), 32'd0);
    chk("rst_ready1", 32'(cif.req1_ready), 32'd0);
    chk("rst_rsp0",   32'(cif.rsp0_valid), 32'd0);
    chk("rst_rsp1",   32'(cif.rsp1_valid), 32'd0);
    chk("rst_data",   32'(cif.rsp_data),   32'd0);
    chk("rst_busy",   32'(busy),           32'd0);
    chk("rst_done",   32'(drain_done),     32'd0);
    inflight.delete();
    last_gnt = 1;
    mode = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
  endtask

  initial begin
    pv[0] = 0; pv[1] = 0; pa[0] = 0; pa[1] = 0; pb[0] = 0; pb[1] = 0; pop[0] = 0; pop[1] = 0;
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    drive();
    #1;
    do_reset();

    // Single add on req0.
    repeat (3) step();
    set_req(0, 8'd3, 8'd5, OP_ADD);
    repeat (8) step();

    // Contention: both continuously valid, grants must alternate from req0.
    for (int k = 0; k < 8; k++) begin
      if (!pv[0]) set_req(0, 8'd12, 8'd12, OP_MUL);
      if (!pv[1]) set_req(1, 8'd200, 8'd100, OP_ADD);
      step();
    end
    repeat (6) step();

    // Back-to-back on req1 with extreme operands.
    set_req(1, 8'd255, 8'd255, OP_MUL);
    step();
    set_req(1, 8'd0, 8'd0, OP_ADD);
    repeat (7) step();

    // Drain with three ops in flight, requesters still pushing.
    for (int k = 0; k < 3; k++) begin
      if (!pv[0]) set_req(0, 8'(k + 1), 8'd7, OP_MUL);
      if (!pv[1]) set_req(1, 8'(k + 9), 8'd4, OP_ADD);
      step();
    end
    drain_req = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      refill(0, 100); refill(1, 100);
      step();
    end
    chk("drain_reached", 32'(saw_done), 32'd1);
    drain_req = 1'b0;
    repeat (8) step();

    // Reset with two ops in flight; no stale responses, req0 wins first tie.
    set_req(0, 8'd9, 8'd9, OP_MUL);
    set_req(1, 8'd1, 8'd2, OP_ADD);
    repeat (2) step();
    do_reset();
    set_req(0, 8'd4, 8'd4, OP_ADD);
    set_req(1, 8'd6, 8'd6, OP_MUL);
    repeat (8) step();

    // Random traffic with occasional drains and resets.
    for (int k = 0; k < 1500; k++) begin
      refill(0, 55);
      refill(1, 55);
      if ($urandom_range(99) < 3) drain_req = ~drain_req;
      if ($urandom_range(499) == 0) do_reset();
      step();
    end
    drain_req = 1'b0;
    repeat (8) step();

    chk("acc0_nonzero", 32'(acc_cnt[0] > 20), 32'd1);
    chk("acc1_nonzero", 32'(acc_cnt[1] > 20), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/au_share_ctrl.md
# au_share_ctrl

Two-requester scheduler that shares one 8-bit pipelined add/multiply unit (4-cycle latency, no stall) between two clients. It arbitrates round-robin, issues at most one operation per cycle and tracks in-flight operations with a tag pipeline. Each result is returned to the requester that issued it. It also provides a drain mechanism so software or a power controller can quiesce the unit. It sits between the client blocks and the arithmetic unit instance at subsystem top level.

## Interface
- `DW`, 8, operand width
- `RW`, 16, result width (2*DW)
- `LAT`, 4, arithmetic unit latency in cycles from issue to result
- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `req0_valid` / `req1_valid` in 1: operation request
- `req0_ready` / `req1_ready` out 1: request accepted this cycle
- `req0_a`, `req0_b` / `req1_a`, `req1_b` in DW: operands
- `req0_op` / `req1_op` in 1: 0 = add, 1 = multiply
- `rsp0_valid` / `rsp1_valid` out 1: one-cycle result strobe per requester
- `rsp_data` out RW: result, shared by both requesters, qualified by the rsp strobes
- `au_a`, `au_b` out DW; `au_op_sel` out 1: drive the unit inputs
- `au_result` in RW: unit output
- `drain_req` in 1: level; stop accepting requests and empty the pipe
- `drain_done` out 1: pipe empty while draining
- `busy` out 1: at least one operation in flight

## Operation
- Handshake: valid/ready. A request is accepted in a cycle where `reqN_valid & reqN_ready` is true.
  - Requester holds valid and operands stable until accepted.
  - `ready` is combinational from valid, the arbitration pointer and state. There is no combinational path from `ready` back to `valid`.
- Arbitration:
  - At most one ready per cycle.
  - Single requester valid: it is granted.
  - Both valid: the requester not granted most recently wins.
  - The pointer updates only on acceptance.
  - Reset pointer = last granted is req1, so req0 wins the first tie.
- Issue:
  - In an accept cycle, `au_a`/`au_b`/`au_op_sel` carry the winner's fields.
  - Otherwise they carry zeros (a bubble).
- Tag pipe: LAT-deep shift register of {valid, requester id}. Entry 0 loads on every clock edge with the accept/id of that cycle. The unit always advances, so there is no stall.
- Response: when tag[LAT-1] is valid, pulse `rsp{id}_valid` and set `rsp_data = au_result`. The requester must consume the response; there is no backpressure.
- FSM, three states:
  - RUN: accept normally.
    - RUN→DRAIN when `drain_req = 1`.
  - DRAIN: `ready` is forced to 0.
    - DRAIN→DRAINED when the tag pipe has no valid bits.
    - If `drain_req` drops while in DRAIN, the FSM returns to RUN.
  - DRAINED: `drain_done = 1`.
    - DRAINED→RUN when `drain_req = 0`.
- `busy` = OR of the tag-pipe valid bits.
- Reset mid-operation:
  - All in-flight tags are discarded and no responses are produced for them.
  - The unit's reset is tied to `~rst_n` at top level.

## Timing
- Reset values: `req*_ready` = 0 until a valid arrives in RUN. `rsp0_valid` = `rsp1_valid` = 0, `rsp_data` = 0, `drain_done` = 0, `busy` = 0. State = RUN, tags all invalid.
- Latency: a request accepted in cycle n produces its rsp strobe in cycle n+LAT (n+4 by default), aligned with `au_result`.
- Throughput: one acceptance per cycle. With both requesters continuously valid, grants alternate 0,1,0,1.
- `drain_req` rising in cycle n blocks acceptance from cycle n+1. Any acceptance in cycle n itself still completes.
- `drain_done` rises no later than 1 cycle after the final response.
- With the pipe already empty: `drain_req` high in cycle n → `drain_done` high in cycle n+2.

## Structure
- Shared package `au_pkg`:
  - `OP_ADD` = 0, `OP_MUL` = 1
  - default `LAT` = 4
  - FSM state typedef {RUN, DRAIN, DRAINED}
  - tag struct {valid, id}
- Sub-module `rr_arb2`: 2-way round-robin grant with a pointer register and an update enable.
- This block does not instantiate the arithmetic unit.

## Test plan
- Single op: req0 a=3, b=5, op=add accepted in cycle 10 → `rsp0_valid` in cycle 14 with `rsp_data` = 8; `rsp1_valid` stays 0.
- Contention: both valid continuously. req0 mul 12×12, req1 add 200+100 → grants alternate starting with req0; responses in order with data 144 and 300, each on the correct strobe.
- Back-to-back: req1 issues 255×255 then 0+0 on consecutive cycles → 65025 then 0 on consecutive cycles; `busy` high throughout.
- Drain: 3 ops in flight, assert `drain_req` → no further acceptance; 3 responses delivered; `drain_done` high; deassert `drain_req` → next request accepted.
- Reset mid-flight: 2 ops in flight, pulse `rst_n` low → no rsp strobes afterwards; all outputs at reset values; first post-reset tie goes to req0.
